// File: rtl/motor_cmd_ramp.sv
// Purpose : slew-limited, dead-time-protected speed ramp feeding a 2-channel PWM motor driver.
// Latency : duty outputs follow the internal speed one clk after each ramp tick; estop clears duties on the next clk.
// Backpress: none; cmd_valid is a fire-and-forget strobe, the newest command always wins.
//
// Ports:
//   clk_50, rst_n           - clock (posedge) and asynchronous active-low reset
//   cmd_valid, cmd_m1/m2    - strobe loading signed 9-bit speed targets (+ = forward)
//   estop                   - level emergency stop, overrides everything
//   duty_cycle{1,2}_fwd/back- per-motor 8-bit duties, never both nonzero for a motor
//   settled                 - both channels in RUN with speed equal to target

// One motor channel: target register, ramp/dead-time FSM, duty mapping.
module motor_cmd_ramp_ch #(
  parameter int RAMP_STEP  = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       estop,
  input  logic       load,
  input  logic [8:0] cmd,
  output logic [7:0] duty_fwd,
  output logic [7:0] duty_back,
  output logic       settled
);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  localparam int                DW   = $clog2(DEAD_TICKS + 1);
  localparam logic signed [9:0] STEP = 10'(RAMP_STEP);

  state_t                state_q, state_d;
  logic signed [9:0]     cur_q, cur_d;
  logic signed [9:0]     tgt_q, tgt_d;
  logic        [DW-1:0]  dead_q, dead_d;
  logic                  last_neg_q, last_neg_d;
  logic        [7:0]     fwd_q, fwd_d;
  logic        [7:0]     back_q, back_d;

  logic signed [9:0]     cmd_sat;
  logic signed [9:0]     diff;
  logic signed [9:0]     neg_cur;
  logic signed [9:0]     toward_tgt;
  logic signed [9:0]     toward_zero;
  logic                  cur_nz, cur_neg, tgt_nz, tgt_neg;

  // -256 has no positive counterpart in the duty range, so clamp it.
  assign cmd_sat = (cmd == 9'h100) ? -10'sd255 : {cmd[8], cmd};

  assign cur_nz  = (cur_q != '0);
  assign cur_neg = cur_q[9];
  assign tgt_nz  = (tgt_q != '0);
  assign tgt_neg = tgt_q[9];
  assign diff    = tgt_q - cur_q;
  assign neg_cur = -cur_q;

  always_comb begin
    toward_tgt = tgt_q;
    if (diff > STEP)
      toward_tgt = cur_q + STEP;
    else if (diff < -STEP)
      toward_tgt = cur_q - STEP;
  end

  always_comb begin
    toward_zero = '0;
    if (cur_q > STEP)
      toward_zero = cur_q - STEP;
    else if (cur_q < -STEP)
      toward_zero = cur_q + STEP;
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    dead_d     = dead_q;
    last_neg_d = cur_nz ? cur_neg : last_neg_q;

    // The tick below deliberately uses tgt_q, so a command landing on a
    // tick cycle only takes effect from the following tick.
    if (load)
      tgt_d = cmd_sat;

    if (tick) begin
      case (state_q)
        RUN: begin
          if (cur_nz && tgt_nz && (cur_neg != tgt_neg)) begin
            cur_d = toward_zero;
          end else if (!cur_nz && tgt_nz && (tgt_neg != last_neg_q)) begin
            state_d = DEAD;
            dead_d  = DW'(DEAD_TICKS);
          end else begin
            cur_d = toward_tgt;
          end
        end
        DEAD: begin
          if (!tgt_nz || (tgt_neg == last_neg_q)) begin
            // Reversal abandoned: no need to sit out the rest of the interval.
            state_d = RUN;
            dead_d  = '0;
          end else if (dead_q == DW'(1)) begin
            // Dead time served: adopt the new direction so RUN does not
            // re-enter DEAD on the next tick while cur is still 0.
            state_d    = RUN;
            dead_d     = '0;
            last_neg_d = tgt_neg;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end

    fwd_d  = (cur_nz && !cur_neg) ? cur_q[7:0]   : 8'd0;
    back_d = cur_neg              ? neg_cur[7:0] : 8'd0;

    if (estop) begin
      state_d = RUN;
      cur_d   = '0;
      tgt_d   = '0;
      dead_d  = '0;
      fwd_d   = 8'd0;
      back_d  = 8'd0;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cur_q      <= '0;
      tgt_q      <= '0;
      dead_q     <= '0;
      last_neg_q <= 1'b0;
      fwd_q      <= 8'd0;
      back_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      dead_q     <= dead_d;
      last_neg_q <= last_neg_d;
      fwd_q      <= fwd_d;
      back_q     <= back_d;
    end
  end

  assign duty_fwd  = fwd_q;
  assign duty_back = back_q;
  assign settled   = (state_q == RUN) && (cur_q == tgt_q);

endmodule

module motor_cmd_ramp #(
  parameter int RAMP_DIV   = 50000,
  parameter int RAMP_STEP  = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [8:0] cmd_m1,
  input  logic [8:0] cmd_m2,
  input  logic       estop,
  output logic [7:0] duty_cycle1_fwd,
  output logic [7:0] duty_cycle1_back,
  output logic [7:0] duty_cycle2_fwd,
  output logic [7:0] duty_cycle2_back,
  output logic       settled
);

  localparam int CW = $clog2(RAMP_DIV);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          load;
  logic          settled1, settled2;

  // Free-running ramp timebase; commands and estop do not disturb its phase.
  assign tick = (tick_cnt == CW'(RAMP_DIV - 1));

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  assign load = cmd_valid & ~estop;

  motor_cmd_ramp_ch #(.RAMP_STEP(RAMP_STEP), .DEAD_TICKS(DEAD_TICKS)) u_ch1 (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .tick      (tick),
    .estop     (estop),
    .load      (load),
    .cmd       (cmd_m1),
    .duty_fwd  (duty_cycle1_fwd),
    .duty_back (duty_cycle1_back),
    .settled   (settled1)
  );

  motor_cmd_ramp_ch #(.RAMP_STEP(RAMP_STEP), .DEAD_TICKS(DEAD_TICKS)) u_ch2 (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .tick      (tick),
    .estop     (estop),
    .load      (load),
    .cmd       (cmd_m2),
    .duty_fwd  (duty_cycle2_fwd),
    .duty_back (duty_cycle2_back),
    .settled   (settled2)
  );

  assign settled = settled1 & settled2;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Purpose : self-checking bench for motor_cmd_ramp (RAMP_DIV=4, RAMP_STEP=4, DEAD_TICKS=3).
// Latency : samples duties one clk after each ramp tick, on the falling edge.
// Backpress: none.
module tb_motor_cmd_ramp;

  localparam int RD = 4;
  localparam int RS = 4;
  localparam int DT = 3;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [8:0] cmd_m1, cmd_m2;
  logic       estop;
  logic [7:0] d1f, d1b, d2f, d2b;
  logic       settled;

  motor_cmd_ramp #(.RAMP_DIV(RD), .RAMP_STEP(RS), .DEAD_TICKS(DT)) dut (
    .clk_50           (clk_50),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_m1           (cmd_m1),
    .cmd_m2           (cmd_m2),
    .estop            (estop),
    .duty_cycle1_fwd  (d1f),
    .duty_cycle1_back (d1b),
    .duty_cycle2_fwd  (d2f),
    .duty_cycle2_back (d2b),
    .settled          (settled)
  );

  always #5 clk_50 = ~clk_50;

  // Reference tick phase: value of the ramp timebase between edges.
  logic [1:0] phase;
  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) phase <= 2'd0;
    else        phase <= (phase == 2'(RD - 1)) ? 2'd0 : phase + 2'd1;
  end

  typedef struct {
    logic [7:0] f1, b1, f2, b2;
    logic       st;
    int         tag;
  } exp_t;

  typedef struct {
    int         m1, m2, nticks;
    logic [7:0] f1, b1, f2, b2;
    logic       st;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];
  int   seq3[10];
  int   total   = 0;
  int   bad     = 0;
  int   overlap = 0;

  always @(negedge clk_50) begin
    if (rst_n === 1'b1 && ((d1f != 8'd0 && d1b != 8'd0) || (d2f != 8'd0 && d2b != 8'd0)))
      overlap++;
  end

  task automatic push_exp(input logic [7:0] f1, input logic [7:0] b1,
                          input logic [7:0] f2, input logic [7:0] b2,
                          input logic st, input int tag);
    exp_t e;
    e.f1 = f1; e.b1 = b1; e.f2 = f2; e.b2 = b2; e.st = st; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: DUT sample with no expected entry");
    end else begin
      e = sb.pop_front();
      if ({d1f, d1b, d2f, d2b, settled} !== {e.f1, e.b1, e.f2, e.b2, e.st}) begin
        bad++;
        $display("FAIL tag%0d: got f1=%0d b1=%0d f2=%0d b2=%0d settled=%0b, want f1=%0d b1=%0d f2=%0d b2=%0d settled=%0b",
                 e.tag, d1f, d1b, d2f, d2b, settled, e.f1, e.b1, e.f2, e.b2, e.st);
      end
    end
  endtask

  // Advance to the falling edge just after the duty register has taken the
  // result of the next ramp tick.
  task automatic wait_tick_out();
    int n = 0;
    while (phase != 2'd3 && n < 10) begin
      @(negedge clk_50);
      n++;
    end
    if (phase != 2'd3) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: phase=%0d, want 3", phase);
    end
    @(negedge clk_50);
    @(negedge clk_50);
  endtask

  // Issue a command whose load edge is never a tick edge.
  task automatic send_cmd(input int m1, input int m2);
    while (phase == 2'd3) @(negedge clk_50);
    cmd_m1    = 9'(m1);
    cmd_m2    = 9'(m2);
    cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_valid = 1'b0;
  endtask

  initial begin
    vt[0] = '{-256,  255,  70, 8'd0,   8'd255, 8'd255, 8'd0,   1'b1};
    vt[1] = '{-256, -256, 140, 8'd0,   8'd255, 8'd0,   8'd255, 1'b1};
    vt[2] = '{0,       0,  70, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1};
    vt[3] = '{-20,    20,  12, 8'd0,   8'd20,  8'd20,  8'd0,   1'b1};
    vt[4] = '{3,      20,  12, 8'd3,   8'd0,   8'd20,  8'd0,   1'b1};
    seq3  = '{6, 2, 0, 0, 0, 0, 0, -4, -8, -8};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_m1 = '0; cmd_m2 = '0; estop = 1'b0;

    // Reset state, then idle.
    repeat (3) @(negedge clk_50);
    push_exp(0, 0, 0, 0, 1'b1, 1);
    check_pop();
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50);
    push_exp(0, 0, 0, 0, 1'b1, 2);
    check_pop();

    // Forward ramp on both motors.
    send_cmd(10, 255);
    for (int k = 1; k <= 64; k++)
      push_exp(8'((4*k > 10) ? 10 : 4*k), 0, 8'((4*k > 255) ? 255 : 4*k), 0, (k == 64), 100 + k);
    for (int k = 1; k <= 64; k++) begin
      wait_tick_out();
      check_pop();
    end

    // Reversal of motor 1 through zero with dead time.
    send_cmd(-8, 255);
    for (int i = 0; i < 10; i++)
      push_exp(8'((seq3[i] > 0) ? seq3[i] : 0), 8'((seq3[i] < 0) ? -seq3[i] : 0),
               8'd255, 8'd0, (i >= 8), 200 + i);
    for (int i = 0; i < 10; i++) begin
      wait_tick_out();
      check_pop();
    end

    // Table: saturation, double reversal, return to zero, mixed directions.
    for (int i = 0; i < 5; i++) begin
      send_cmd(vt[i].m1, vt[i].m2);
      push_exp(vt[i].f1, vt[i].b1, vt[i].f2, vt[i].b2, vt[i].st, 300 + i);
      repeat (vt[i].nticks) wait_tick_out();
      check_pop();
    end

    // Command landing on a tick edge: that tick still uses the old target.
    while (phase != 2'd3) @(negedge clk_50);
    cmd_m1 = 9'd11; cmd_m2 = 9'd20; cmd_valid = 1'b1;
    @(negedge clk_50);
    cmd_valid = 1'b0;
    push_exp(3, 0, 20, 0, 1'b0, 400);
    push_exp(7, 0, 20, 0, 1'b0, 401);
    push_exp(11, 0, 20, 0, 1'b1, 402);
    @(negedge clk_50);
    check_pop();
    wait_tick_out(); check_pop();
    wait_tick_out(); check_pop();

    // Estop mid-ramp, with a simultaneous command that must be ignored.
    send_cmd(40, 20);
    push_exp(40, 0, 20, 0, 1'b1, 500);
    repeat (10) wait_tick_out();
    check_pop();
    send_cmd(100, 20);
    push_exp(44, 0, 20, 0, 1'b0, 501);
    wait_tick_out(); check_pop();
    estop = 1'b1; cmd_valid = 1'b1; cmd_m1 = 9'd100;
    push_exp(0, 0, 0, 0, 1'b1, 502);
    @(negedge clk_50);
    check_pop();
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk_50);
    estop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 0, 0, 0, 1'b1, 510 + i);
      wait_tick_out();
      check_pop();
    end
    send_cmd(8, 30);
    push_exp(4, 0, 4, 0, 1'b0, 520);
    wait_tick_out(); check_pop();
    push_exp(8, 0, 30, 0, 1'b1, 521);
    repeat (7) wait_tick_out();
    check_pop();

    // Reset in the middle of DEAD.
    send_cmd(-8, 30);
    push_exp(0, 0, 30, 0, 1'b0, 600);
    repeat (3) wait_tick_out();
    check_pop();
    #3 rst_n = 1'b0;
    push_exp(0, 0, 0, 0, 1'b1, 601);
    #1 check_pop();
    @(negedge clk_50);
    rst_n = 1'b1;
    send_cmd(8, 0);
    push_exp(4, 0, 0, 0, 1'b0, 602);
    push_exp(8, 0, 0, 0, 1'b1, 603);
    wait_tick_out(); check_pop();
    wait_tick_out(); check_pop();

    total++;
    if (overlap != 0) begin
      bad++;
      $display("FAIL fwd_back_overlap: got %0d overlapping samples, want 0", overlap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
